// File: rtl/adc_rec_if.sv
// ---------------------------------------------------------------------------
// adc_rec_if
// Sample-SRAM write-side bus of the audio capture stage.
//   data     assembled 16-bit sample presented to the SRAM
//   we       SRAM write strobe, one bclk cycle per sample
//   full     take reached its last address (sticky, or a one-cycle pulse
//            in the ring-buffer build)
//   addr_oe  high while the capture stage owns the SRAM address bus; the
//            address itself is a separate tri-state port on adc_rec
// Modports: master = capture stage (drives), slave = SRAM side (observes).
// ---------------------------------------------------------------------------
interface adc_rec_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              we;
    logic              full;
    logic              addr_oe;

    modport master (output data, output we, output full, output addr_oe);
    modport slave  (input  data, input  we, input  full, input  addr_oe);
endinterface

// File: rtl/adc_rec.sv
// ---------------------------------------------------------------------------
// adc_rec
// Left-channel ADC capture. Deserializes the codec's adclrc/adcdat stream
// (MSB first, left half-frame = adclrc low) into 16-bit words and writes
// them to consecutive SRAM addresses starting at 0 on every new take.
// Everything runs on bclk.
//
// Ports:
//   bclk     codec bit clock, the only clock
//   rst      synchronous active-high reset
//   record   level, high = capture enabled
//   adclrc   codec ADC frame clock, 0 = left half-frame
//   adcdat   codec ADC serial data
//   addr     SRAM word address; driven while record=1, high-Z otherwise
//   bus      adc_rec_if master: data, we, full, addr_oe
//
// Build option: define ADC_REC_WRAP_EN to turn the take into a ring buffer
// (address wraps to 0 after LAST_ADDR, full pulses for one cycle). Without
// it the take stops at LAST_ADDR with full sticky.
// ---------------------------------------------------------------------------
module adc_rec #(
    parameter int                ADDR_W    = 18,
    parameter int                DATA_W    = 16,
    // All ones, i.e. 18'h3FFFF at the default width.
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              record,
    input  logic              adclrc,
    input  logic              adcdat,
    output logic [ADDR_W-1:0] addr,
    adc_rec_if.master         bus
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_L,
        SHIFT,
        WRITE,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic              we_reg,    we_next;
    logic              full_reg,  full_next;
    logic [3:0]        cnt_reg,   cnt_next;

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            we_reg    <= 1'b0;
            full_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            we_reg    <= we_next;
            full_reg  <= full_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        we_next    = 1'b0;
        cnt_next   = cnt_reg;
`ifdef ADC_REC_WRAP_EN
        // Ring buffer: full is only a one-cycle wrap marker.
        full_next  = 1'b0;
`else
        full_next  = full_reg;
`endif

        if (!record) begin
            // Dropping record abandons any partial word. A strobe already
            // in flight (WRITE) is a registered output, so it still
            // completes its cycle.
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    addr_next  = '0;
                    full_next  = 1'b0;
                    state_next = SYNC;
                end
                SYNC: begin
                    // Wait for the right half so we never start mid-word.
                    if (adclrc) state_next = WAIT_L;
                end
                WAIT_L: begin
                    if (!adclrc) begin
                        data_next[DATA_W-1] = adcdat;
                        cnt_next            = 4'd14;
                        state_next          = SHIFT;
                    end
                end
                SHIFT: begin
                    if (adclrc) begin
                        // Short left half-frame: drop the word, resync.
                        state_next = WAIT_L;
                    end else begin
                        data_next[cnt_reg] = adcdat;
                        if (cnt_reg == 4'd0) begin
                            we_next    = 1'b1;
                            state_next = WRITE;
                        end else begin
                            cnt_next = cnt_reg - 4'd1;
                        end
                    end
                end
                WRITE: begin
                    if (addr_reg == LAST_ADDR) begin
`ifdef ADC_REC_WRAP_EN
                        addr_next  = '0;
                        full_next  = 1'b1;
                        state_next = SYNC;
`else
                        full_next  = 1'b1;
                        state_next = DONE;
`endif
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = SYNC;
                    end
                end
                DONE: begin
                    // Hold LAST_ADDR and full until record drops.
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The address bus is released combinationally as soon as record drops.
    assign addr        = record ? addr_reg : {ADDR_W{1'bz}};
    assign bus.addr_oe = record;
    assign bus.data    = data_reg;
    assign bus.we      = we_reg;
    assign bus.full    = full_reg;

endmodule

// File: tb/tb_adc_rec.sv
// ---------------------------------------------------------------------------
// tb_adc_rec
// Directed bench for adc_rec with LAST_ADDR shrunk to 4 so the end-of-take
// behaviour is reachable. Frames are 32 bclk (16 left, 16 right) unless a
// short left half is requested. Expectations follow ADC_REC_WRAP_EN.
// ---------------------------------------------------------------------------
module tb_adc_rec;

    logic        bclk = 1'b0;
    logic        rst;
    logic        record;
    logic        adclrc;
    logic        adcdat;
    wire  [17:0] addr;

    adc_rec_if #(.DATA_W(16)) bus ();

    adc_rec #(
        .ADDR_W    (18),
        .DATA_W    (16),
        .LAST_ADDR (18'd4)
    ) dut (
        .bclk   (bclk),
        .rst    (rst),
        .record (record),
        .adclrc (adclrc),
        .adcdat (adcdat),
        .addr   (addr),
        .bus    (bus)
    );

    always #5 bclk = ~bclk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        we_prev   = 1'b0;
    logic        full_prev = 1'b0;
    int          full_rises = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Write logger, sampled mid-cycle.
    always @(negedge bclk) begin
        if (bus.we === 1'b1) begin
            check("we_one_cycle", {31'b0, we_prev}, 32'd0);
            got_addr.push_back({14'b0, addr});
            got_data.push_back({16'b0, bus.data});
            $display("write addr=%0d data=0x%04h", addr, bus.data);
        end
        if (bus.full === 1'b1 && full_prev === 1'b0) full_rises++;
        we_prev   = bus.we;
        full_prev = bus.full;
    end

    task automatic expect_write(input logic [17:0] a, input logic [15:0] d);
        exp_addr.push_back({14'b0, a});
        exp_data.push_back({16'b0, d});
    endtask

    task automatic verify_writes(input string tag);
        check({tag, "_count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    // Right-half filler cycles.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge bclk);
            adclrc = 1'b1;
            adcdat = 1'b0;
        end
    endtask

    // One frame: nleft left-half bits of w (MSB first), then 16 right-half
    // cycles. record rises/falls at left index rec_on/rec_off (-1 = never).
    // chk_we >= 0 checks the strobe just after the edge sampling bit 0.
    task automatic frame(input logic [15:0] w, input int nleft, input int rec_on,
                         input int rec_off, input int chk_we);
        for (int i = 0; i < nleft; i++) begin
            @(negedge bclk);
            if (i == rec_on)  record = 1'b1;
            if (i == rec_off) record = 1'b0;
            adclrc = 1'b0;
            adcdat = w[15-i];
        end
        if (chk_we >= 0) begin
            @(posedge bclk);
            #1;
            check("we_after_bit0", {31'b0, bus.we}, chk_we[31:0]);
        end
        gap(16);
    endtask

    task automatic start_take();
        @(negedge bclk);
        record = 1'b1;
        adclrc = 1'b1;
        gap(3);
    endtask

    task automatic stop_take();
        @(negedge bclk);
        record = 1'b0;
        gap(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        record = 1'b1;
        adclrc = 1'b1;
        adcdat = 1'b0;

        // Reset with record held high.
        repeat (2) @(negedge bclk);
        check("rst_we",   {31'b0, bus.we},   32'd0);
        check("rst_full", {31'b0, bus.full}, 32'd0);
        check("rst_data", {16'b0, bus.data}, 32'd0);
        check("rst_addr", {14'b0, addr},     32'd0);
        record = 1'b0;
        #1;
        check("rst_addr_released", {31'b0, bus.addr_oe}, 32'd0);
        @(negedge bclk);
        rst = 1'b0;
        gap(2);

        // Three full frames.
        start_take();
        frame(16'hA5C3, 16, -1, -1, 1);
        frame(16'h0001, 16, -1, -1, 1);
        frame(16'hFFFF, 16, -1, -1, 1);
        expect_write(18'd0, 16'hA5C3);
        expect_write(18'd1, 16'h0001);
        expect_write(18'd2, 16'hFFFF);
        verify_writes("three");
        stop_take();

        // record rises mid-left-half: that word is skipped.
        frame(16'hBEEF, 16, 4, -1, 0);
        frame(16'h1234, 16, -1, -1, 1);
        expect_write(18'd0, 16'h1234);
        verify_writes("midstart");
        stop_take();

        // record drops after 8 bits: no write, then a fresh take at 0.
        start_take();
        frame(16'h5555, 16, -1, 8, 0);
        check("drop_addr_released", {31'b0, bus.addr_oe}, 32'd0);
        start_take();
        frame(16'h00F0, 16, -1, -1, 1);
        expect_write(18'd0, 16'h00F0);
        verify_writes("drop");
        stop_take();

        // End of take at LAST_ADDR=4, six frames.
        full_rises = 0;
        start_take();
        frame(16'h1000, 16, -1, -1, 1);
        frame(16'h2001, 16, -1, -1, 1);
        frame(16'h3002, 16, -1, -1, 1);
        frame(16'h4003, 16, -1, -1, 1);
        frame(16'h5004, 16, -1, -1, 1);
`ifdef ADC_REC_WRAP_EN
        frame(16'h6005, 16, -1, -1, 1);
`else
        frame(16'h6005, 16, -1, -1, 0);
`endif
        expect_write(18'd0, 16'h1000);
        expect_write(18'd1, 16'h2001);
        expect_write(18'd2, 16'h3002);
        expect_write(18'd3, 16'h4003);
        expect_write(18'd4, 16'h5004);
`ifdef ADC_REC_WRAP_EN
        expect_write(18'd0, 16'h6005);
        check("last_full_end",  {31'b0, bus.full}, 32'd0);
`else
        check("last_full_end",  {31'b0, bus.full}, 32'd1);
        check("last_addr_hold", {14'b0, addr},     32'd4);
`endif
        check("last_full_rises", full_rises, 32'd1);
        verify_writes("last");
        stop_take();
`ifndef ADC_REC_WRAP_EN
        check("full_sticky_idle", {31'b0, bus.full}, 32'd1);
`endif

        // Short left half-frame (10 bclk): no write, address unchanged.
        start_take();
        check("full_cleared_new_take", {31'b0, bus.full}, 32'd0);
        frame(16'hC0DE, 16, -1, -1, 1);
        frame(16'hDEAD, 10, -1, -1, -1);
        frame(16'h7E57, 16, -1, -1, 1);
        expect_write(18'd0, 16'hC0DE);
        expect_write(18'd1, 16'h7E57);
        verify_writes("short");
        stop_take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
